calc_top_unit: RTL and testbench
================================

# calc_top_unit

Top level of the 8-digit unsigned decimal calculator, RTL module `calc_top`. It decodes a 4-bit command, accumulates decimal operands and evaluates +, − and × left to right. It drives eight 7-segment digits plus a 2-bit status code. It sits directly under the board wrapper, which maps `cmd` to switches/keypad and `displays`/`status` to the on-board 7-segment digits and LEDs.

## Interface
- No parameters. Fixed widths: 8 display digits; 27-bit binary value range 0..99 999 999.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd` in 4: 0–9 digit; 1010 add; 1011 sub; 1100 mul; 1101 NOP; 1110 equals; 1111 clear.
- `displays` out 7×[8] (`logic [6:0] displays [7:0]`): active-low segments {g,f,e,d,c,b,a}; index 0 is the rightmost, least significant digit.
- `status` out 2: 00 FIRST, 01 SECOND, 10 RESULT, 11 ERROR.

## Operation
- Command acceptance is edge-based.
  - `cmd` is registered into `cmd_q`, and the previous value into `cmd_prev`.
  - A command executes once, in the cycle where `cmd_q != cmd_prev`. Holding a value executes it only once.
  - To repeat the same key, first go through NOP.
- Registers: `acc` (entry/result, 27 bits), `opa` (27 bits), `op` (2 bits), and `state` = status encoding.
- Digit d:
  - In FIRST or SECOND: `acc <= acc*10 + d`, ignored if `acc >= 10 000 000` (8-digit limit).
  - In RESULT: `acc <= d`, state goes to FIRST.
- Operator:
  - FIRST or RESULT: `opa <= acc`, `op <= cmd`, `acc <= 0`, state goes to SECOND.
  - SECOND (chaining): `opa <= opa op acc`, `op <= new`, `acc <= 0`, state stays SECOND.
- Equals:
  - SECOND: `acc <= opa op acc`, state goes to RESULT.
  - FIRST or RESULT: no-op.
- Arithmetic is single-cycle combinational. The product is computed 54 bits wide.
  - A result > 99 999 999 goes to ERROR.
  - A subtraction with `acc > opa` (negative) goes to ERROR.
- Clear (from any state): `acc = opa = 0`, `op = add`, state goes to FIRST.
- ERROR: all commands except clear are ignored.
- NOP: does nothing (acts as the release code).
- Display:
  - `acc` is converted to 8 BCD digits and blanked from the left. Digit 0 always shows, so 0 displays as a single "0".
  - In ERROR: digits 2..0 = "E","r","r"; the rest are blank.
  - Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, r=0101111, blank=1111111.

## Timing
- Reset (async assert, release sync to `clock`):
  - `acc = opa = 0`, state FIRST, `cmd_q = cmd_prev = 1101`.
  - Outputs: `status = 00`, `displays[0] = "0"`, all other digits blank.
- Latency: a `cmd` change that is stable before edge N is registered at N, executed at N+1, and visible on `displays`/`status` after edge N+1.
  - Outputs are registered state plus combinational decode; no busy state.
- Minimum command spacing: 3 cycles, with `cmd` stable.
- Reset mid-entry aborts immediately; no partial result is retained.
- `cmd` = X/Z after reset is not-care until the first valid value.

## Structure
- Package `calc_pkg`: command constants (`CMD_ADD`, `CMD_SUB`, `CMD_MUL`, `CMD_NOP`, `CMD_EQ`, `CMD_CLR`), `status_t` enum, `MAX_VAL = 99_999_999`, 7-segment glyph constants.
- Sub-module `calc_display`: combinational binary→BCD (double-dabble, 27→32 bits), leading-zero blanking, error glyph override, and segment encode.
- `calc_top` holds: edge detector, state machine, ALU.

## Test plan
- Reset, then cmd 1,2,+,3,= (15 cycles each):
  - Status sequence: 00,00,01,01,10.
  - Final display "15" (`displays[1]` = 1111001, `displays[0]` = 0010010), other digits blank.
- 9 entered nine times with NOP between each: display 99999999; the ninth digit is ignored.
- 1,0,0,0,0 × 1,0,0,0,0 = → status 11, "Err".
  - Then digit 5: still ERROR.
  - Then clear: status 00, display "0".
- 3 − 5 = → ERROR. 8 − 3 = → "5", status 10.
- Chaining 2 + 3 × 4 = → "20".
  - After `=`, digit 7 → status 00, display "7".
- Assert `reset` low mid-entry of "123" → "0" and status 00, regardless of the clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the 8-digit decimal calculator: command codes, status
// encoding, value limits and 7-segment glyphs.
package calc_pkg;

    localparam logic [3:0] CMD_ADD = 4'b1010;
    localparam logic [3:0] CMD_SUB = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_NOP = 4'b1101;
    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_CLR = 4'b1111;

    // Operator register holds the low two bits of the operator command.
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;
    localparam logic [1:0] OP_MUL = 2'b00;

    typedef enum logic [1:0] {
        ST_FIRST  = 2'b00,
        ST_SECOND = 2'b01,
        ST_RESULT = 2'b10,
        ST_ERROR  = 2'b11
    } status_t;

    localparam logic [26:0] MAX_VAL     = 27'd99_999_999;
    localparam logic [26:0] DIGIT_LIMIT = 27'd10_000_000;

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/calc_display.sv
// Combinational display path: binary to BCD, leading-zero blanking,
// "Err" override and 7-segment encoding.
module calc_display
    import calc_pkg::*;
(
    input  logic [26:0] value,
    input  logic        error,
    output logic [6:0]  segs [7:0]
);

    logic [31:0] bcd;
    logic        lead;

    always_comb begin
        bcd  = '0;
        lead = 1'b1;
        for (int k = 0; k < 8; k++) segs[k] = SEG_BLANK;

        // Double-dabble: add 3 to any nibble >= 5 before each shift.
        for (int i = 26; i >= 0; i--) begin
            for (int k = 0; k < 8; k++) begin
                if (bcd[4*k +: 4] >= 4'd5) bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
            bcd = {bcd[30:0], value[i]};
        end

        for (int k = 7; k >= 0; k--) begin
            if (lead && (bcd[4*k +: 4] == 4'd0) && (k != 0)) begin
                segs[k] = SEG_BLANK;
            end else begin
                lead    = 1'b0;
                segs[k] = seg_digit(bcd[4*k +: 4]);
            end
        end

        if (error) begin
            for (int k = 0; k < 8; k++) segs[k] = SEG_BLANK;
            segs[2] = SEG_E;
            segs[1] = SEG_R;
            segs[0] = SEG_R;
        end
    end

endmodule

// File: rtl/calc_top_unit.sv
// Calculator top: command edge detector, entry/evaluation state machine and
// single-cycle ALU, driving the display decoder.
module calc_top_unit
    import calc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  cmd,
    output logic [6:0]  displays [7:0],
    output logic [1:0]  status
);

    logic [3:0]  cmd_q;
    logic [3:0]  cmd_prev;
    logic [26:0] acc;
    logic [26:0] opa;
    logic [1:0]  op;
    status_t     state;

    logic [26:0] acc_nx;
    logic [26:0] opa_nx;
    logic [1:0]  op_nx;
    status_t     state_nx;

    logic        exec;
    logic        is_digit;
    logic        is_op;
    logic [26:0] dig_val;
    logic [53:0] alu_wide;
    logic [26:0] alu_val;
    logic        alu_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_q    <= CMD_NOP;
            cmd_prev <= CMD_NOP;
            acc      <= '0;
            opa      <= '0;
            op       <= OP_ADD;
            state    <= ST_FIRST;
        end else begin
            cmd_q    <= cmd;
            cmd_prev <= cmd_q;
            acc      <= acc_nx;
            opa      <= opa_nx;
            op       <= op_nx;
            state    <= state_nx;
        end
    end

    // Product needs the full 54 bits so overflow is never masked by truncation.
    always_comb begin
        alu_wide = '0;
        case (op)
            OP_ADD:  alu_wide = {27'd0, opa} + {27'd0, acc};
            OP_SUB:  alu_wide = {27'd0, opa} - {27'd0, acc};
            default: alu_wide = {27'd0, opa} * {27'd0, acc};
        endcase
        alu_err = ((op == OP_SUB) && (acc > opa)) || (alu_wide > {27'd0, MAX_VAL});
        alu_val = alu_wide[26:0];
    end

    assign exec     = (cmd_q != cmd_prev);
    assign is_digit = (cmd_q <= 4'd9);
    assign is_op    = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB) || (cmd_q == CMD_MUL);
    // Only used when acc is below the 8-digit limit, so the 27-bit result is exact.
    assign dig_val  = acc * 27'd10 + {23'd0, cmd_q};

    always_comb begin
        acc_nx   = acc;
        opa_nx   = opa;
        op_nx    = op;
        state_nx = state;

        if (exec) begin
            if (cmd_q == CMD_CLR) begin
                acc_nx   = '0;
                opa_nx   = '0;
                op_nx    = OP_ADD;
                state_nx = ST_FIRST;
            end else if (state != ST_ERROR) begin
                if (is_digit) begin
                    if (state == ST_RESULT) begin
                        acc_nx   = {23'd0, cmd_q};
                        state_nx = ST_FIRST;
                    end else if (acc < DIGIT_LIMIT) begin
                        acc_nx = dig_val;
                    end
                end else if (is_op) begin
                    if (state == ST_SECOND) begin
                        if (alu_err) begin
                            state_nx = ST_ERROR;
                        end else begin
                            opa_nx = alu_val;
                            op_nx  = cmd_q[1:0];
                            acc_nx = '0;
                        end
                    end else begin
                        opa_nx   = acc;
                        op_nx    = cmd_q[1:0];
                        acc_nx   = '0;
                        state_nx = ST_SECOND;
                    end
                end else if ((cmd_q == CMD_EQ) && (state == ST_SECOND)) begin
                    if (alu_err) begin
                        state_nx = ST_ERROR;
                    end else begin
                        acc_nx   = alu_val;
                        state_nx = ST_RESULT;
                    end
                end
            end
        end
    end

    assign status = state;

    calc_display u_display (
        .value (acc),
        .error (state == ST_ERROR),
        .segs  (displays)
    );

endmodule

// File: tb/tb_calc_top_unit.sv
// Bench for calc_top_unit: directed key sequences and random command streams
// compared against a decimal behavioural model of the calculator.
module tb_calc_top_unit;

    localparam int NOP = 13;
    localparam int CLR = 15;
    localparam int ADD = 10;
    localparam int SUB = 11;
    localparam int MUL = 12;
    localparam int EQ  = 14;
    localparam longint LIMIT = 99_999_999;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [3:0] cmd;
    logic [6:0] displays [7:0];
    logic [1:0] status;

    int vectors    = 0;
    int miscompares = 0;

    longint m_acc, m_opa;
    int     m_op, m_state, m_last;

    always #5 clock = ~clock;

    calc_top_unit dut (
        .clock    (clock),
        .reset    (rst_n),
        .cmd      (cmd),
        .displays (displays),
        .status   (status)
    );

    function automatic logic [6:0] glyph(input longint d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic longint pow10(input int k);
        longint p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        if (m_state == 3) begin
            if (k == 2) return 7'b0000110;
            if (k < 2)  return 7'b0101111;
            return 7'b1111111;
        end
        if (k > 0 && m_acc < pow10(k)) return 7'b1111111;
        return glyph((m_acc / pow10(k)) % 10);
    endfunction

    function automatic longint calc(input longint a, input int o, input longint b);
        if (o == ADD) return a + b;
        if (o == SUB) return a - b;
        return a * b;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_opa = 0; m_op = ADD; m_state = 0; m_last = NOP;
    endtask

    task automatic model(input int c);
        longint r;
        if (c == m_last) return;
        m_last = c;
        if (c == CLR) begin
            m_acc = 0; m_opa = 0; m_op = ADD; m_state = 0;
        end else if (m_state == 3) begin
            return;
        end else if (c <= 9) begin
            if (m_state == 2) begin
                m_acc = c; m_state = 0;
            end else if (m_acc < 10_000_000) begin
                m_acc = m_acc * 10 + c;
            end
        end else if (c == ADD || c == SUB || c == MUL) begin
            if (m_state == 1) begin
                r = calc(m_opa, m_op, m_acc);
                if (r < 0 || r > LIMIT) m_state = 3;
                else begin m_opa = r; m_op = c; m_acc = 0; end
            end else begin
                m_opa = m_acc; m_op = c; m_acc = 0; m_state = 1;
            end
        end else if (c == EQ && m_state == 1) begin
            r = calc(m_opa, m_op, m_acc);
            if (r < 0 || r > LIMIT) m_state = 3;
            else begin m_acc = r; m_state = 2; end
        end
    endtask

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] es;
        vectors++;
        assert (status === 2'(m_state)) else begin
            miscompares++;
            $error("FAIL %s status: observed %b expected %b", tag, status, 2'(m_state));
        end
        for (int k = 0; k < 8; k++) begin
            es = exp_seg(k);
            vectors++;
            assert (displays[k] === es) else begin
                miscompares++;
                $error("FAIL %s digit%0d: observed %b expected %b", tag, k, displays[k], es);
            end
        end
    endtask

    task automatic press(input int c, input string tag);
        @(negedge clock);
        cmd = 4'(c);
        model(c);
        repeat (3) @(negedge clock);
        check_all(tag);
    endtask

    task automatic key(input int c, input string tag);
        press(c, tag);
        press(NOP, tag);
    endtask

    initial begin
        int c, sel;
        cmd   = 4'(NOP);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
        check_all("post_reset");

        // 1 2 + 3 = -> 15
        key(1, "e1_d1"); key(2, "e1_d2"); key(ADD, "e1_add"); key(3, "e1_d3"); key(EQ, "e1_eq");
        check_val("e1_digit1", displays[1], 7'b1111001);
        check_val("e1_digit0", displays[0], 7'b0010010);
        check_val("e1_status", {5'd0, status}, 7'b0000010);

        // Nine 9s: ninth ignored
        key(CLR, "e2_clr");
        for (int i = 0; i < 9; i++) key(9, "e2_nine");
        check_val("e2_digit7", displays[7], 7'b0010000);

        // 10000 * 10000 overflows
        key(CLR, "e3_clr");
        key(1, "e3_a"); for (int i = 0; i < 4; i++) key(0, "e3_a0");
        key(MUL, "e3_mul");
        key(1, "e3_b"); for (int i = 0; i < 4; i++) key(0, "e3_b0");
        key(EQ, "e3_eq");
        check_val("e3_status", {5'd0, status}, 7'b0000011);
        key(5, "e3_ignored");
        key(CLR, "e3_clear");
        check_val("e3_zero", displays[0], 7'b1000000);

        // Negative subtraction, then a valid one
        key(3, "e4_a"); key(SUB, "e4_sub"); key(5, "e4_b"); key(EQ, "e4_eq");
        key(CLR, "e4_clr");
        key(8, "e5_a"); key(SUB, "e5_sub"); key(3, "e5_b"); key(EQ, "e5_eq");
        check_val("e5_five", displays[0], 7'b0010010);

        // Chaining 2 + 3 * 4 = 20, then a fresh digit
        key(CLR, "e6_clr");
        key(2, "e6_a"); key(ADD, "e6_add"); key(3, "e6_b"); key(MUL, "e6_mul"); key(4, "e6_c"); key(EQ, "e6_eq");
        check_val("e6_tens", displays[1], 7'b0100100);
        key(7, "e6_seven");

        // Reset mid-entry, asserted between clock edges
        key(CLR, "e7_clr");
        key(1, "e7_d1"); key(2, "e7_d2"); press(3, "e7_d3");
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        cmd   = 4'(NOP);
        model_reset();
        #1;
        check_all("e7_async_reset");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
        check_all("e7_released");

        // Random command stream, including held repeats
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      c = int'($urandom_range(0, 9));
            else if (sel < 63) c = ADD;
            else if (sel < 70) c = SUB;
            else if (sel < 76) c = MUL;
            else if (sel < 84) c = EQ;
            else if (sel < 94) c = NOP;
            else               c = CLR;
            press(c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
